// File: rtl/cpu_player.sv
// rtl/cpu_player.sv - paced pseudo-random press generator acting as the CPU tug-of-war player
// Optional feature macro: CPU_PLAYER_PRESS_COUNT_EN builds the saturating press counter.
module cpu_player #(
  parameter int TICK_DIV = 5_000_000,
  parameter int MIN_GAP  = 1
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       enable,
  input  logic [9:0] level,
  output logic       press,
  output logic [9:0] lfsr,
  output logic [7:0] press_count
);

  localparam int               DIV_W    = $clog2(TICK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [3:0]       GAP_LOAD = 4'(MIN_GAP);

  logic [DIV_W-1:0] r_div_cnt;
  logic [9:0]       r_lfsr;
  logic [3:0]       r_gap_cnt;
  logic             r_press;

  logic             w_tick;
  logic             w_fire;
  logic [9:0]       w_lfsr_next;

  // One decision tick per prescaler wrap; the decision uses the pre-advance LFSR value.
  assign w_tick      = (r_div_cnt == DIV_LAST);
  assign w_lfsr_next = {r_lfsr[8:0], ~(r_lfsr[9] ^ r_lfsr[6])};
  assign w_fire      = w_tick && enable && (r_gap_cnt == 4'd0) && (level > r_lfsr);

  // Free-running prescaler, independent of enable so pacing never drifts.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_div_cnt <= '0;
    end else if (w_tick) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + DIV_W'(1);
    end
  end

  // XNOR LFSR stepping once per tick; all-ones lock-up is unreachable from zero.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_lfsr <= 10'h000;
    end else if (w_tick) begin
      r_lfsr <= w_lfsr_next;
    end
  end

  // Press decision and cooldown: gap_cnt == 0 is READY, nonzero is COOLDOWN.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_gap_cnt <= 4'd0;
      r_press   <= 1'b0;
    end else begin
      r_press <= w_fire;
      if (w_tick) begin
        if (!enable) begin
          r_gap_cnt <= 4'd0;
        end else if (r_gap_cnt != 4'd0) begin
          r_gap_cnt <= r_gap_cnt - 4'd1;
        end else if (level > r_lfsr) begin
          r_gap_cnt <= GAP_LOAD;
        end
      end
    end
  end

`ifdef CPU_PLAYER_PRESS_COUNT_EN
  logic [7:0] r_press_count;

  // Saturating count of issued presses, stepping on the edge that raises press.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_press_count <= 8'd0;
    end else if (w_fire && (r_press_count != 8'hFF)) begin
      r_press_count <= r_press_count + 8'd1;
    end
  end

  assign press_count = r_press_count;
`else
  assign press_count = 8'd0;
`endif

  assign press = r_press;
  assign lfsr  = r_lfsr;

endmodule

// File: tb/tb_cpu_player.sv
// tb/tb_cpu_player.sv - directed self-checking bench for cpu_player
module tb_cpu_player;

`ifdef CPU_PLAYER_PRESS_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       Clock = 1'b0;
  logic       Reset;
  logic       en0, en2;
  logic [9:0] lvl0, lvl2;
  logic       press0, press2;
  logic [9:0] lfsr0, lfsr2;
  logic [7:0] pc0, pc2;

  int n_checks = 0;
  int n_errors = 0;

  cpu_player #(.TICK_DIV(4), .MIN_GAP(0)) u_dut0 (
    .Clock(Clock), .Reset(Reset), .enable(en0), .level(lvl0),
    .press(press0), .lfsr(lfsr0), .press_count(pc0)
  );

  cpu_player #(.TICK_DIV(4), .MIN_GAP(2)) u_dut2 (
    .Clock(Clock), .Reset(Reset), .enable(en2), .level(lvl2),
    .press(press2), .lfsr(lfsr2), .press_count(pc2)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // Holds reset, checks reset values, releases 1 ns after an edge so the next edge is edge 1.
  task automatic do_reset();
    Reset = 1'b0;
    step();
    step();
    chk("rst_press0", 32'(press0), 32'd0);
    chk("rst_lfsr0",  32'(lfsr0),  32'd0);
    chk("rst_pc0",    32'(pc0),    32'd0);
    chk("rst_press2", 32'(press2), 32'd0);
    chk("rst_lfsr2",  32'(lfsr2),  32'd0);
    chk("rst_pc2",    32'(pc2),    32'd0);
    Reset = 1'b1;
  endtask

  function automatic logic [9:0] lfsr_step(input logic [9:0] v);
    return {v[8:0], ~(v[9] ^ v[6])};
  endfunction

  initial begin
    int          seen_press;
    int          first_leave;
    logic [9:0]  m;
    int          exp_pc, got_pc, dups, hit3ff, model_mis;
    logic [1023:0] seen;
    logic        exp0, exp2;
    int          exp_cnt;

    Reset = 1'b0;
    en0 = 1'b1; en2 = 1'b1;
    lvl0 = 10'd0; lvl2 = 10'd0;

    // Level 0 never presses; LFSR first moves on the first tick.
    do_reset();
    seen_press  = 0;
    first_leave = 0;
    for (int e = 1; e <= 4096; e++) begin
      step();
      if (press0 || press2) seen_press++;
      if ((first_leave == 0) && (lfsr0 != 10'd0)) first_leave = e;
    end
    chk("lvl0_no_press",    32'(seen_press),  32'd0);
    chk("lfsr_first_leave", 32'(first_leave), 32'd4);
    chk("lvl0_pc",          32'(pc0),         32'd0);

    // Full LFSR period with level 512: track states and count presses against the model.
    lvl0 = 10'd512;
    do_reset();
    m = 10'd0; exp_pc = 0; got_pc = 0; dups = 0; hit3ff = 0; model_mis = 0;
    seen = '0;
    seen[0] = 1'b1;
    for (int e = 1; e <= 4092; e++) begin
      step();
      if (press0) got_pc++;
      if ((e % 4) == 0) begin
        if (m < 10'd512) exp_pc++;
        m = lfsr_step(m);
        if (lfsr0 !== m) model_mis++;
        if (e < 4092) begin
          if (lfsr0 == 10'h3FF) hit3ff++;
          if (seen[lfsr0]) dups++;
          seen[lfsr0] = 1'b1;
        end else begin
          chk("lfsr_period_return", 32'(lfsr0), 32'd0);
        end
      end
    end
    chk("lfsr_model",     32'(model_mis), 32'd0);
    chk("lfsr_no_3ff",    32'(hit3ff),    32'd0);
    chk("lfsr_no_repeat", 32'(dups),      32'd0);
    chk("lvl512_presses", 32'(got_pc),    32'(exp_pc));
    chk("lvl512_pc",      32'(pc0),       CNT_EN ? 32'd255 : 32'd0);

    // Level 1023: every tick on dut0, every third tick on dut2 with an enable drop mid-cooldown.
    lvl0 = 10'd1023; lvl2 = 10'd1023;
    do_reset();
    for (int e = 1; e <= 1204; e++) begin
      step();
      exp0 = ((e % 4) == 0);
      chk($sformatf("press0_e%0d", e), 32'(press0), 32'(exp0));
      if (e <= 48) begin
        exp2 = (e == 4) || (e == 16) || (e == 28) || (e == 40) || (e == 48);
        chk($sformatf("press2_e%0d", e), 32'(press2), 32'(exp2));
        if (e == 41) en2 = 1'b0;
        if (e == 45) en2 = 1'b1;
        if (e == 48) chk("pc2_e48", 32'(pc2), CNT_EN ? 32'd5 : 32'd0);
      end
      if (e == 1000) begin
        exp_cnt = CNT_EN ? 250 : 0;
        chk("pc0_e1000", 32'(pc0), 32'(exp_cnt));
      end
      if (e == 1200) chk("pc0_sat", 32'(pc0), CNT_EN ? 32'd255 : 32'd0);
    end

    // Asynchronous reset in the middle of a press pulse, away from any clock edge.
    #1;
    Reset = 1'b0;
    #1;
    chk("async_press0", 32'(press0), 32'd0);
    chk("async_pc0",    32'(pc0),    32'd0);
    chk("async_lfsr0",  32'(lfsr0),  32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/cpu_player.md
# cpu_player

Computer opponent for the tug-of-war game. Generates single-cycle "press" pulses on a paced, pseudo-random schedule, using a 10-bit LFSR compared against a difficulty level. Its output drives the same one-pulse press input of the light chain and display that a debounced human button drives. It sits beside the button conditioners in the top level and replaces one human player.

## Interface
Parameters:
- `TICK_DIV`, default 5_000_000: Clock cycles per decision tick (10 Hz at 50 MHz). Must be ≥ 2.
- `MIN_GAP`, default 1: minimum number of decision ticks skipped after each press (0..15).

Ports:
- `Clock` in, 1: system clock (CLOCK_50).
- `Reset` in, 1: asynchronous, active-low reset.
- `enable` in, 1: game in play. Low while a player has won or the game is paused.
- `level` in, 10: difficulty, unsigned. Larger values mean more frequent presses.
- `press` out, 1: one-cycle press pulse, same semantics as a button conditioner output.
- `lfsr` out, 10: current LFSR state, for debug and HEX display.
- `press_count` out, 8: saturating count of presses issued (see Configuration).

## Operation
- Prescaler `div_cnt` counts 0..TICK_DIV-1, then wraps to 0. `tick` is high for the cycle in which `div_cnt == TICK_DIV-1`. The prescaler runs regardless of `enable`.
- LFSR: 10-bit Fibonacci, XNOR feedback, polynomial x^10+x^7+1.
  - next = {lfsr[8:0], ~(lfsr[9] ^ lfsr[6])}.
  - Advances only on tick and runs regardless of `enable`.
  - The all-ones lock-up state is unreachable from reset. The period is 1023 ticks.
- Decision on each tick, using the pre-advance `lfsr` value:
  - `enable` low: no press, `gap_cnt <= 0`.
  - `gap_cnt != 0`: no press, `gap_cnt <= gap_cnt - 1`.
  - Otherwise, if `level > lfsr` (unsigned 10-bit compare), set press and `gap_cnt <= MIN_GAP`.
  - Otherwise, no press.
- `press` is a register. It is high for exactly the one cycle following a tick that issued a press, and low on every other cycle.
- `enable` falling forces `press` low from the next edge. A pulse already registered completes its single cycle.
- Effective rate: level=0 never presses. level=1023 presses on every eligible tick, because `lfsr` never reaches 1023.
- State machine (implicit in `gap_cnt`):
  - READY (`gap_cnt == 0`) → COOLDOWN on a press.
  - COOLDOWN → READY after MIN_GAP ticks.
  - Either state → READY when `enable` is low.

## Timing
- Reset values (asynchronous, on `Reset == 0`): `div_cnt = 0`, `lfsr = 10'h000`, `gap_cnt = 0`, `press = 0`, `press_count = 0`.
- First tick occurs TICK_DIV cycles after `Reset` deasserts. A possible first `press` occurs the cycle after that tick.
- Latency: tick cycle → `press` high on the next edge (1 cycle), high for 1 cycle only.
- Minimum spacing between press pulses is (MIN_GAP+1)·TICK_DIV cycles.
- `level` and `enable` are sampled only on the tick edge. Changes between ticks have no effect until the next tick, except that `enable` low also clears `gap_cnt` at that tick.
- Reset mid-pulse: `press` drops immediately. Reset mid-cooldown: cooldown is discarded.

## Configuration
- `CPU_PLAYER_PRESS_COUNT_EN`, defined:
  - `press_count` is an 8-bit counter that increments on the same edge `press` rises.
  - It saturates at 255 and clears only on reset.
- Not defined:
  - `press_count` is tied to 8'd0 and no counter logic is built.

## Test plan
Test parameters: TICK_DIV=4, MIN_GAP=0 unless stated. Macro defined for scenario 5.
1. Reset held low, then released with `enable=1`, level=0. Run 4096 cycles → `press` stays 0, `lfsr` first leaves 0 after cycle 4, `press_count` stays 0.
2. level=1023, MIN_GAP=0 → `press` pulses 1 cycle wide, exactly every 4 cycles, first at cycle 5 after reset release.
3. level=1023, MIN_GAP=2 → one pulse every 12 cycles. Dropping `enable` mid-cooldown, then raising it, gives a press on the first tick after re-enable.
4. Track `lfsr` across ticks from reset → returns to 10'h000 after exactly 1023 ticks, never equals 10'h3FF, and shows no repeated state earlier.
5. level=1023, run 300 ticks → `press_count` reaches 255 and holds. Assert `Reset` low mid-pulse → `press` and `press_count` go to 0 in the same cycle, without waiting for a clock edge.
6. level=512, 1023 ticks → press count equals the number of LFSR states below 512 within the period, ±0 (computed by the bench reference model).
